// File: rtl/riscv_pkg.sv
// Shared encodings for the RV M-extension multiply/divide unit:
// funct3 operation codes and the sequencer state encoding.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV M-extension multiply/divide unit. Operands are converted to
// magnitudes on accept; a radix-2 shift-add multiplier and a restoring
// divider share one adder/subtractor and one 2*XLEN accumulator. The FIX
// state restores the sign and selects the result half.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A1,
    input  logic [XLEN-1:0] A2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Y
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic                neg_q, neg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     y_q, y_d;

    op_e                 f_in;
    logic                sa, sb, res_neg, div0, ovf, accept, is_div;
    logic [XLEN-1:0]     mag_a, mag_b, special_y;
    logic [XLEN+1:0]     add_a, add_b, add_s;
    logic                add_sub;
    logic [2*XLEN-1:0]   step_acc, prod_fix;
    logic [XLEN-1:0]     q_fix, r_fix, fix_y;

    // Operand conditioning: signedness, magnitudes and early-out detection.
    always_comb begin
        f_in    = op_e'(funct3);
        sa      = A1[XLEN-1] && (f_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb      = A2[XLEN-1] && (f_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a   = sa ? -A1 : A1;
        mag_b   = sb ? -A2 : A2;
        res_neg = (f_in == OP_REM) ? sa : (sa ^ sb);
        div0    = funct3[2] && (A2 == '0);
        ovf     = (f_in inside {OP_DIV, OP_REM}) && (A1 == SMIN) && (A2 == '1);
        if (div0) special_y = funct3[1] ? A1 : '1;
        else      special_y = funct3[1] ? '0 : A1;
    end

    // Shared adder: adds the multiplicand or subtracts the divisor.
    always_comb begin
        is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        if (is_div) begin
            add_a   = {1'b0, acc_q[2*XLEN-1:XLEN-1]};
            add_b   = {2'b00, b_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {2'b00, acc_q[2*XLEN-1:XLEN]};
            add_b   = acc_q[0] ? {2'b00, b_q} : '0;
            add_sub = 1'b0;
        end
        add_s = add_a + (add_b ^ {(XLEN+2){add_sub}}) + {{(XLEN+1){1'b0}}, add_sub};
    end

    // One iteration step and the final sign fix / result selection.
    always_comb begin
        if (is_div) begin
            if (add_s[XLEN+1]) step_acc = {acc_q[2*XLEN-2:0], 1'b0};
            else               step_acc = {add_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = {add_s[XLEN:0], acc_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -acc_q : acc_q;
        q_fix    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        r_fix    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_y = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_y = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_y = q_fix;
            default:                      fix_y = r_fix;
        endcase
    end

    // Next-state and datapath update; flush overrides everything else.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        y_d     = y_q;
        accept  = start && !flush && (state_q == S_IDLE || state_q == S_DONE);

        case (state_q)
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
            end
            S_FIX: begin
                y_d     = fix_y;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            op_d  = f_in;
            neg_d = res_neg;
            cnt_d = '0;
            if (div0 || ovf) begin
                y_d     = special_y;
                state_d = S_DONE;
            end else begin
                state_d = S_CALC;
                // Multiply iterates over A2 bits with A1 as addend; divide
                // shifts the dividend A1 through and subtracts A2.
                acc_d = {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                b_d   = funct3[2] ? mag_b : mag_a;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            y_d     = y_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            y_q     <= y_d;
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign Y    = y_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (XLEN=64): table-driven vectors
// through a result scoreboard, plus hand sequences for flush, ignored
// start, asynchronous reset and back-to-back issue.
module tb_riscv_muldiv;

    localparam int XLEN = 64;
    localparam int NORM = XLEN + 2;

    logic            clk = 1'b0;
    logic            rst, start, flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] A1, A2;
    logic            busy, done;
    logic [XLEN-1:0] Y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] y;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] y;
        int          lat;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    riscv_muldiv #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .A1     (A1),
        .A2     (A2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .Y      (Y)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic [2:0] vf, input logic [63:0] va, input logic [63:0] vb,
                        input logic [63:0] vy, input int vl);
        vec_t v;
        v.f = vf; v.a = va; v.b = vb; v.y = vy; v.lat = vl;
        vt.push_back(v);
    endtask

    // Drive a request at the current negedge and record its expected result.
    task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] y, input int lat);
        exp_t e;
        start = 1'b1; funct3 = f; A1 = a; A2 = b;
        e.y = y; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called lat0 negedges after the accepting edge; waits for done and compares.
    task automatic wait_done(input string nm, input int lat0);
        exp_t e;
        int   lat;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", nm);
            return;
        end
        e = sb.pop_front();
        check({nm, " busy"}, {63'b0, busy}, (e.lat > lat0) ? 64'd1 : 64'd0);
        lat = lat0;
        while (done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " done"}, {63'b0, done}, 64'd1);
        check({nm, " latency"}, 64'(lat), 64'(e.lat));
        check({nm, " Y"}, Y, e.y);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] y, input int lat, input string nm);
        @(negedge clk);
        issue(f, a, b, y, lat);
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        addv(3'b000, 64'd7, -64'sd3, -64'sd21, NORM);
        addv(3'b000, '1, '1, 64'd1, NORM);
        addv(3'b000, 64'h8000_0000_0000_0000, 64'd2, 64'd0, NORM);
        addv(3'b001, '1, '1, 64'd0, NORM);
        addv(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, NORM);
        addv(3'b001, 64'd7, -64'sd3, '1, NORM);
        addv(3'b010, '1, 64'd2, '1, NORM);
        addv(3'b010, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, NORM);
        addv(3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, NORM);
        addv(3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, NORM);
        addv(3'b100, -64'sd20, 64'd3, -64'sd6, NORM);
        addv(3'b110, -64'sd20, 64'd3, -64'sd2, NORM);
        addv(3'b101, 64'd20, 64'd3, 64'd6, NORM);
        addv(3'b111, 64'd20, 64'd3, 64'd2, NORM);
        addv(3'b100, 64'd20, -64'sd3, -64'sd6, NORM);
        addv(3'b110, 64'd20, -64'sd3, 64'd2, NORM);
        addv(3'b100, -64'sd21, -64'sd7, 64'd3, NORM);
        addv(3'b110, -64'sd21, -64'sd7, 64'd0, NORM);
        addv(3'b101, '1, 64'd7, 64'h2492_4924_9249_2492, NORM);
        addv(3'b111, '1, 64'd7, 64'd1, NORM);
        addv(3'b101, 64'd5, 64'd0, '1, 1);
        addv(3'b111, 64'd5, 64'd0, 64'd5, 1);
        addv(3'b100, -64'sd7, 64'd0, '1, 1);
        addv(3'b110, -64'sd7, 64'd0, -64'sd7, 1);
        addv(3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        addv(3'b110, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; A1 = '0; A2 = '0;
        #1;
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset Y", Y, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            do_op(vt[i].f, vt[i].a, vt[i].b, vt[i].y, vt[i].lat, $sformatf("vec%0d", i));

        // Start pulses while busy must not disturb the running DIVU.
        @(negedge clk);
        issue(3'b101, 64'd100, 64'd7, 64'd14, NORM);
        @(negedge clk);
        funct3 = 3'b011; A1 = '1; A2 = '1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done("start ignored", 4);

        // Flush 10 cycles into a MUL: no done, Y keeps the previous result.
        do_op(3'b000, 64'd3, 64'd5, 64'd15, NORM, "pre-flush");
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; A1 = 64'd1000; A2 = 64'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush busy", {63'b0, busy}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush Y held", Y, 64'd15);

        // Flush together with start in IDLE drops the start.
        start = 1'b1; flush = 1'b1; funct3 = 3'b101; A1 = 64'd9; A2 = 64'd0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {63'b0, busy}, 64'd0);
        check("flush+start done", {63'b0, done}, 64'd0);
        check("flush+start Y", Y, 64'd15);

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; A1 = -64'sd20; A2 = 64'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid rst busy", {63'b0, busy}, 64'd0);
        check("mid rst done", {63'b0, done}, 64'd0);
        check("mid rst Y", Y, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(3'b100, -64'sd20, 64'd3, -64'sd6, NORM, "after rst");

        // Back-to-back issue from DONE, including into an early-out op.
        @(negedge clk);
        issue(3'b101, 64'd20, 64'd3, 64'd6, NORM);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b first", 1);
        issue(3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, NORM);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b second", 1);
        issue(3'b111, 64'd5, 64'd0, 64'd5, 1);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b third", 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv.md
RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 Parameter XLEN, default 64, operand and result width; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request valid; sampled only when busy=0.
REQ-005 funct3  input  3  RV M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 A1  input  XLEN  rs1 operand (multiplicand / dividend).
REQ-007 A2  input  XLEN  rs2 operand (multiplier / divisor).
REQ-008 flush  input  1  abort in-flight op (branch taken in MEM).
REQ-009 busy  output  1  high while an op is in flight; EX-stage stall request.
REQ-010 done  output  1  one-cycle pulse, Y valid.
REQ-011 Y  output  XLEN  result; held stable until the next accepted start.

Function
REQ-012 FSM states: IDLE, CALC, FIX, DONE; IDLE->CALC on accepted start; CALC->FIX after XLEN iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-013 busy=1 in CALC and FIX; busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-014 start with busy=1 ignored; start in DONE accepted (back-to-back ops), DONE->CALC instead of IDLE.
REQ-015 On accept: latch funct3; latch operand magnitudes and result sign per op signedness (MULH both signed, MULHSU A1 signed only, DIV/REM signed, rest unsigned).
REQ-016 Multiply: radix-2 shift-add, one multiplier bit per CALC cycle, 2*XLEN-bit accumulator.
REQ-017 Divide: restoring, one quotient bit per CALC cycle, XLEN-bit quotient and remainder.
REQ-018 FIX applies two's-complement sign correction; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits; quotient sign = sign(A1) xor sign(A2); remainder sign = sign(A1).
REQ-019 Latency: start accepted at edge N, done=1 during cycle N+XLEN+2 (XLEN CALC + FIX + DONE).
REQ-020 Divide by zero: skip CALC, IDLE->DONE directly (done in cycle N+1); DIV/DIVU Y = all ones, REM/REMU Y = A1.
REQ-021 Signed overflow (DIV/REM, A1 = -2^(XLEN-1), A2 = -1): skip CALC; DIV Y = A1, REM Y = 0; done in cycle N+1.
REQ-022 flush=1 in any state: next state IDLE, no done pulse, Y unchanged; flush and start same cycle: flush wins, start dropped.
REQ-023 Iteration counter width clog2(XLEN)+1; no wrap beyond XLEN.

Reset
REQ-024 rst=1 forces state IDLE, busy=0, done=0, Y=0, counter=0, accumulators=0, regardless of clock.
REQ-025 rst asserted mid-operation discards the op; first start after rst deassertion is accepted normally.

Structure
REQ-026 funct3 op encodings and FSM state encoding live in shared package riscv_pkg.
REQ-027 Single module, no sub-modules; datapath shared between multiply and divide (one adder/subtractor).

Verification (XLEN=64)
REQ-028 MUL A1=7, A2=-3 -> done at cycle 66 after start, Y=-21; MULHU A1=A2=2^64-1 -> Y=2^64-2.
REQ-029 DIV A1=-20, A2=3 -> Y=-6; REM same operands -> Y=-2; DIVU A1=20, A2=3 -> Y=6.
REQ-030 DIVU A1=5, A2=0 -> done in next cycle, Y=0xFFFFFFFFFFFFFFFF; REMU -> Y=5.
REQ-031 DIV A1=0x8000000000000000, A2=-1 -> done next cycle, Y=0x8000000000000000; REM -> Y=0.
REQ-032 flush 10 cycles into MUL -> busy drops next cycle, no done, Y keeps prior value; start during busy ignored.
REQ-033 rst pulse mid-DIV -> all outputs 0 immediately; back-to-back start in DONE accepted with no idle cycle.
